// File: rtl/hyper_resp_pkg.sv
// Shared types and constants for the HyperRAM device-side responder.
// The CA layout mirrors the 48-bit command/address phase, MSB first.
package hyper_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CA,
    LAT,
    XFER,
    WAIT_CS
  } state_e;

  typedef struct packed {
    logic        rw;
    logic        as;
    logic        burst;
    logic [28:0] row_col_hi;
    logic [12:0] rsvd;
    logic [2:0]  col_lo;
  } ca_t;

  localparam int          CaWords  = 3;
  localparam logic [15:0] Cr0Reset = 16'h8F1F;

endpackage

// File: rtl/hyper_resp_mem.sv
// Word-wide single-port SRAM with per-byte write enables and a registered read.
// Contents are deliberately never reset.
module hyper_resp_mem
  import hyper_resp_pkg::*;
#(
  parameter int MemWords = 65536,
  parameter int AddrW    = $clog2(MemWords)
) (
  input  logic             clk_i,
  input  logic             re,
  input  logic [1:0]       we,
  input  logic [AddrW-1:0] addr,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata
);

  logic [15:0] mem [MemWords];

  always_ff @(posedge clk_i) begin
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
    if (we[0]) mem[addr][7:0]  <= wdata[7:0];
    if (re)    rdata           <= mem[addr];
  end

endmodule

// File: rtl/hyper_ram_responder.sv
// HyperRAM device-side responder at word level: decodes CA, counts initial
// latency, then serves linear or wrapped bursts from memory or register space.
module hyper_ram_responder
  import hyper_resp_pkg::*;
#(
  parameter int          MemWords      = 65536,
  parameter int          LatencyCycles = 6,
  parameter int          FixedLatency  = 1,
  parameter int          WrapWords     = 16,
  parameter logic [15:0] IdValue       = 16'h0C81
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        cs_ni,
  input  logic [15:0] dq_i,
  input  logic [1:0]  rwds_i,
  input  logic        force_2x_i,
  output logic [15:0] dq_o,
  output logic        dq_oe_o,
  output logic [1:0]  rwds_o,
  output logic        rwds_oe_o
);

  localparam int            AW       = $clog2(MemWords);
  localparam logic [AW-1:0] WrapMask = AW'(WrapWords - 1);

  state_e        state, state_n;
  logic [1:0]    ca_cnt;
  logic [3:0]    lat_cnt;
  logic          lat2x;
  logic          lat2x_now;
  logic [15:0]   ca0, ca1;
  ca_t           ca_dec;
  logic [31:0]   ca_addr;
  logic [AW-1:0] dec_addr;
  logic          ca_last;
  logic [3:0]    ltot;
  logic          rw, as, burst;
  logic [AW-1:0] addr;
  logic [15:0]   cr0;
  logic [15:0]   reg_rdata;
  logic [15:0]   mem_rdata;
  logic          fetch;
  logic          wr_mem, wr_reg;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_we;
  logic          unused_bits;

  // Wrapped bursts only advance the low bits inside the wrap window.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic linear);
    logic [AW-1:0] inc;
    inc = a + 1'b1;
    if (linear) return inc;
    return (a & ~WrapMask) | (inc & WrapMask);
  endfunction

  assign lat2x_now   = (FixedLatency != 0) || force_2x_i;
  assign ca_dec      = {ca0, ca1, dq_i};
  assign ca_addr     = {ca_dec.row_col_hi, ca_dec.col_lo};
  assign dec_addr    = ca_addr[AW-1:0];
  assign ca_last     = (state == CA) && (ca_cnt == 2'(CaWords - 1));
  assign ltot        = (ca_dec.as && !ca_dec.rw) ? 4'd0 : (4'(LatencyCycles) << lat2x);
  assign unused_bits = ^{ca_dec.rsvd, ca_addr};

  // Reads fetch one cycle ahead of the word that goes out on DQ.
  assign fetch = !cs_ni && ((ca_last && ca_dec.rw && (ltot == 4'd0)) ||
                            ((state == LAT) && (lat_cnt == 4'd0) && rw) ||
                            ((state == XFER) && rw));
  assign mem_addr = ca_last ? dec_addr : addr;
  assign wr_mem   = (state == XFER) && !rw && !as && !cs_ni;
  assign wr_reg   = (state == XFER) && !rw && as && !cs_ni && (addr != '0);
  assign mem_we   = wr_mem ? ~rwds_i : 2'b00;

  hyper_resp_mem #(
    .MemWords(MemWords),
    .AddrW   (AW)
  ) u_mem (
    .clk_i(clk_i),
    .re   (fetch),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(dq_i),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      state   <= IDLE;
      cr0     <= Cr0Reset;
      ca_cnt  <= 2'd0;
      lat_cnt <= 4'd0;
      lat2x   <= 1'b0;
    end else begin
      state <= state_n;
      if (wr_reg) cr0 <= dq_i;
      if (state == IDLE) begin
        ca_cnt <= 2'd1;
        lat2x  <= lat2x_now;
      end else if (state == CA) begin
        ca_cnt <= ca_cnt + 2'd1;
      end
      if (ca_last)             lat_cnt <= ltot - 4'd1;
      else if (state == LAT)   lat_cnt <= lat_cnt - 4'd1;
    end
  end

  // Datapath: CA capture, burst address and register read data.
  always_ff @(posedge clk_i) begin
    if (state == IDLE) ca0 <= dq_i;
    if ((state == CA) && (ca_cnt == 2'd1)) ca1 <= dq_i;
    if (ca_last) begin
      rw    <= ca_dec.rw;
      as    <= ca_dec.as;
      burst <= ca_dec.burst;
      addr  <= fetch ? next_addr(dec_addr, ca_dec.burst) : dec_addr;
    end else if (fetch || (state == XFER)) begin
      addr <= next_addr(addr, burst);
    end
    if (fetch) reg_rdata <= (mem_addr == '0) ? IdValue : cr0;
  end

  always_comb begin
    state_n   = state;
    dq_o      = '0;
    dq_oe_o   = 1'b0;
    rwds_o    = 2'b00;
    rwds_oe_o = 1'b0;
    if (cs_ni) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_n = CA;
        CA:      if (ca_last) state_n = (ltot == 4'd0) ? XFER : LAT;
        LAT:     if (lat_cnt == 4'd0) state_n = XFER;
        XFER:    if (!rw && as) state_n = WAIT_CS;
        default: state_n = state;
      endcase
    end
    if (!cs_ni && !rst_n) begin
      case (state)
        IDLE: begin
          rwds_oe_o = 1'b1;
          rwds_o    = {2{lat2x_now}};
        end
        CA: begin
          rwds_oe_o = 1'b1;
          rwds_o    = {2{lat2x}};
        end
        XFER: begin
          if (rw) begin
            dq_oe_o   = 1'b1;
            dq_o      = as ? reg_rdata : mem_rdata;
            rwds_oe_o = 1'b1;
            rwds_o    = 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hyper_ram_responder.sv
// Scoreboard bench for hyper_ram_responder: a fixed-latency and a variable-latency
// instance share the bus; read words are predicted from a bench-side memory model.
module tb_hyper_ram_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cs_a = 1'b1, cs_b = 1'b1;
  logic [15:0] dq = '0;
  logic [1:0]  rwds = '0;
  logic        f2x = 1'b0;
  logic        sel = 1'b0;

  logic [15:0] a_dq, b_dq, m_dq;
  logic        a_dq_oe, b_dq_oe, m_dq_oe;
  logic [1:0]  a_rwds, b_rwds, m_rwds;
  logic        a_rwds_oe, b_rwds_oe, m_rwds_oe;

  always #5 clk = ~clk;

  hyper_ram_responder #(.FixedLatency(1)) dut_a (
    .clk_i(clk), .rst_n(rst_n), .cs_ni(cs_a), .dq_i(dq), .rwds_i(rwds),
    .force_2x_i(f2x), .dq_o(a_dq), .dq_oe_o(a_dq_oe), .rwds_o(a_rwds), .rwds_oe_o(a_rwds_oe)
  );

  hyper_ram_responder #(.FixedLatency(0)) dut_b (
    .clk_i(clk), .rst_n(rst_n), .cs_ni(cs_b), .dq_i(dq), .rwds_i(rwds),
    .force_2x_i(f2x), .dq_o(b_dq), .dq_oe_o(b_dq_oe), .rwds_o(b_rwds), .rwds_oe_o(b_rwds_oe)
  );

  assign m_dq      = sel ? b_dq : a_dq;
  assign m_dq_oe   = sel ? b_dq_oe : a_dq_oe;
  assign m_rwds    = sel ? b_rwds : a_rwds;
  assign m_rwds_oe = sel ? b_rwds_oe : a_rwds_oe;

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = -1;
  logic [15:0] mdl_a [256];
  logic [15:0] mdl_b [256];
  logic [15:0] cr0_m = 16'h8F1F;
  logic [15:0] wbuf [16];
  logic [1:0]  wmsk [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int adv(input int a, input bit lin);
    if (lin) return (a + 1) & 16'hFFFF;
    return (a & ~15) | ((a + 1) & 15);
  endfunction

  // One bus cycle: drive after the edge, leave the negedge for sampling.
  task automatic drive(input bit cs, input logic [15:0] d, input logic [1:0] m, input bit f, input int c);
    @(posedge clk);
    #1;
    if (sel) begin cs_b = cs; cs_a = 1'b1; end
    else     begin cs_a = cs; cs_b = 1'b1; end
    dq = d; rwds = m; f2x = f; cyc = c;
    @(negedge clk);
  endtask

  function automatic logic [15:0] caw(input bit rd, input bit as, input bit lin, input int addr, input int i);
    logic [47:0] ca;
    ca = '0;
    ca[47] = rd; ca[46] = as; ca[45] = lin;
    ca[44:16] = 29'(addr >> 3);
    ca[2:0] = 3'(addr);
    return ca[47-16*i -: 16];
  endfunction

  task automatic xact(input bit rd, input bit as, input bit lin, input int addr, input int n,
                      input bit f, input int abort_at);
    int lt; bit l2x; int a; exp_t e; logic [15:0] d; logic [1:0] m;
    l2x = !sel || f;
    lt = (as && !rd) ? 0 : (l2x ? 12 : 6);
    a = addr;
    if (rd) begin
      for (int k = 0; k < n; k++) begin
        e.cyc = 32'(3 + lt + k);
        e.data = as ? ((a == 0) ? 16'h0C81 : cr0_m) : (sel ? mdl_b[a & 255] : mdl_a[a & 255]);
        sb.push_back(e);
        a = adv(a, lin);
      end
    end
    for (int c = 0; c < 3 + lt + n; c++) begin
      if (c == abort_at) break;
      d = 16'h0; m = 2'b00;
      if (c < 3) d = caw(rd, as, lin, addr, c);
      else if (c >= 3 + lt && !rd) begin d = wbuf[c-3-lt]; m = wmsk[c-3-lt]; end
      drive(1'b0, d, m, f, c);
      if (c < 3) check("ca_rwds", {29'd0, m_rwds_oe, m_rwds}, {29'd0, 1'b1, {2{l2x}}});
    end
    drive(1'b1, 16'h0, 2'b00, 1'b0, -1);
    check("idle_oe", {30'd0, m_dq_oe, m_rwds_oe}, 32'd0);
    drive(1'b1, 16'h0, 2'b00, 1'b0, -1);
    if (!rd && abort_at < 0) begin
      a = addr;
      for (int k = 0; k < n; k++) begin
        if (as) begin
          if (k == 0 && a != 0) cr0_m = wbuf[0];
        end else begin
          d = sel ? mdl_b[a & 255] : mdl_a[a & 255];
          if (!wmsk[k][1]) d[15:8] = wbuf[k][15:8];
          if (!wmsk[k][0]) d[7:0]  = wbuf[k][7:0];
          if (sel) mdl_b[a & 255] = d; else mdl_a[a & 255] = d;
        end
        a = adv(a, lin);
      end
    end
  endtask

  always @(negedge clk) begin
    if (m_dq_oe === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexp_oe", {31'd0, m_dq_oe}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rd_data", {16'd0, m_dq}, {16'd0, mon_e.data});
        check("rd_cyc", cyc, mon_e.cyc);
        check("rd_rwds", {29'd0, m_rwds_oe, m_rwds}, 32'd6);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) wmsk[i] = 2'b00;
    // Reset state and idle behaviour.
    repeat (2) begin
      @(negedge clk);
      check("rst_out", {13'd0, m_dq, m_dq_oe, m_rwds, m_rwds_oe}, 32'd0);
    end
    rst_n = 1'b0;
    drive(1'b1, 16'h0, 2'b00, 1'b0, -1);
    check("idle_after_rst", {13'd0, m_dq, m_dq_oe, m_rwds, m_rwds_oe}, 32'd0);

    // Register reads at reset: CR0 and ID.
    xact(1'b1, 1'b1, 1'b1, 1, 1, 1'b0, -1);
    xact(1'b1, 1'b1, 1'b1, 0, 1, 1'b0, -1);

    // Linear write then read back.
    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
    xact(1'b0, 1'b0, 1'b1, 'h10, 4, 1'b0, -1);
    xact(1'b1, 1'b0, 1'b1, 'h10, 4, 1'b0, -1);

    // Wrapped read across the 16-word boundary.
    for (int i = 0; i < 16; i++) wbuf[i] = 16'(i);
    xact(1'b0, 1'b0, 1'b1, 0, 16, 1'b0, -1);
    xact(1'b1, 1'b0, 1'b0, 'hE, 4, 1'b0, -1);

    // Masked write keeps the low byte.
    wbuf[0] = 16'h1234;
    xact(1'b0, 1'b0, 1'b1, 5, 1, 1'b0, -1);
    wbuf[0] = 16'hABCD; wmsk[0] = 2'b01;
    xact(1'b0, 1'b0, 1'b1, 5, 1, 1'b0, -1);
    wmsk[0] = 2'b00;
    xact(1'b1, 1'b0, 1'b1, 5, 1, 1'b0, -1);

    // CR0 write with zero latency, then register reads.
    wbuf[0] = 16'h8F17;
    xact(1'b0, 1'b1, 1'b1, 1, 1, 1'b0, -1);
    xact(1'b1, 1'b1, 1'b1, 1, 1, 1'b0, -1);
    xact(1'b1, 1'b1, 1'b1, 0, 1, 1'b0, -1);

    // Aborted writes at c1 leave memory and CR0 untouched.
    wbuf[0] = 16'hDEAD; wbuf[1] = 16'hBEEF;
    xact(1'b0, 1'b0, 1'b1, 'h10, 4, 1'b0, 1);
    xact(1'b0, 1'b1, 1'b1, 1, 1, 1'b0, 1);
    xact(1'b1, 1'b0, 1'b1, 'h10, 2, 1'b0, -1);
    xact(1'b1, 1'b1, 1'b1, 1, 1, 1'b0, -1);

    // Variable-latency instance: single and forced double latency.
    sel = 1'b1;
    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
    xact(1'b0, 1'b0, 1'b1, 'h10, 4, 1'b0, -1);
    xact(1'b1, 1'b0, 1'b1, 'h10, 4, 1'b0, -1);
    xact(1'b1, 1'b0, 1'b1, 'h10, 2, 1'b1, -1);
    drive(1'b1, 16'h0, 2'b00, 1'b0, -1);
    sel = 1'b0;

    // Reset asserted mid-burst clears outputs at once and restores CR0.
    begin
      exp_t e;
      e.cyc = 32'd15;
      e.data = mdl_a['h10];
      sb.push_back(e);
      for (int c = 0; c < 16; c++)
        drive(1'b0, (c < 3) ? caw(1'b1, 1'b0, 1'b1, 'h10, c) : 16'h0, 2'b00, 1'b0, c);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("rst_mid_burst", {13'd0, m_dq, m_dq_oe, m_rwds, m_rwds_oe}, 32'd0);
      @(negedge clk);
      drive(1'b1, 16'h0, 2'b00, 1'b0, -1);
      rst_n = 1'b0;
      repeat (2) begin
        drive(1'b1, 16'h0, 2'b00, 1'b0, -1);
        check("idle_post_rst", {13'd0, m_dq, m_dq_oe, m_rwds, m_rwds_oe}, 32'd0);
      end
      cr0_m = 16'h8F1F;
    end
    xact(1'b1, 1'b1, 1'b1, 1, 1, 1'b0, -1);

    check("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
